ram_pattern_tester: RTL and testbench
=====================================

Name: ram_pattern_tester

Overview:
- Parametrised successor to the board-level block-RAM exerciser. It holds an internal synchronous single-port RAM of DEPTH words by DATA_W bits.
- Keeps the manual mode: switch-selected pattern write, and byte-selected readback onto LED.
- Adds an automatic fill sweep and a verify sweep, with error counting and first-failure capture. The team uses it to self-test the RAM on the board, driven by switches, buttons and LEDs.

Parameters:
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, word width; must be a multiple of 8 and at least 8.
- BSEL_W, 2, byte-select width; must satisfy 2**BSEL_W >= DATA_W/8.
- CNT_W, 8, error-counter width.

Ports:
- Clk, input, 1, sole clock; all logic on the rising edge.
- Rst, input, 1, synchronous active-high reset.
- Mem_Addr, input, ADDR_W, manual word address.
- Mem_Write, input, 1, manual write enable (level).
- C, input, 2, pattern select for manual writes and for both sweeps.
- Byte_Sel, input, BSEL_W, LED byte select.
- Start_Fill, input, 1, begins a fill sweep.
- Start_Verify, input, 1, begins a verify sweep.
- Busy, output, 1, high while a sweep runs.
- Done, output, 1, one-cycle pulse when a sweep ends.
- Fail, output, 1, sticky: the last verify found at least one mismatch.
- Err_Cnt, output, CNT_W, mismatch count of the last verify; saturating.
- Err_Addr, output, ADDR_W, first mismatching address of the last verify.
- LED, output, 8, selected byte of the read data.

Behaviour:
- **Pattern function P(C,a).** The base value is selected by C:
  - C=00: 32'h0055_7523
  - C=01: 32'h1234_5678
  - C=10: 32'h8765_4321
  - C=11: the address a, zero-extended to 32 bits.
  - The 32-bit base is repeated to fill DATA_W, then truncated to the low DATA_W bits.
- **RAM.**
  - Write is synchronous.
  - Read data Rd_Data is registered, so it is valid 1 cycle after the address is sampled.
  - Rd_Data resets to 0; Rst does not clear RAM contents.
- **Reset values.** Busy=0, Done=0, Fail=0, Err_Cnt=0, Err_Addr=0, LED=0; the FSM goes to IDLE.
- **FSM states.** IDLE, FILL, VERIFY, DRAIN.
- **IDLE.**
  - Mem_Write=1 writes P(C, Mem_Addr) to Mem_Addr every cycle that it is high.
  - Mem_Write=0 reads Mem_Addr.
  - Start_Fill=1 moves to FILL with the pointer at 0.
  - Start_Verify=1 moves to VERIFY with the pointer at 0; it also clears Fail, Err_Cnt and Err_Addr that same cycle.
  - Start_Fill has priority when both starts are high.
  - Start takes priority over a manual write in the same cycle; that manual write is dropped.
  - C is latched at start and used for the whole sweep.
- **FILL.**
  - Writes P(Cl, ptr) to ptr, one word per cycle.
  - After ptr = DEPTH-1 it returns to IDLE with Done=1 for that cycle.
  - The sweep takes DEPTH cycles. Fail, Err_Cnt and Err_Addr are untouched.
- **VERIFY.**
  - Issues read address ptr each cycle, for ptr = 0..DEPTH-1.
  - The compare for address ptr happens in the following cycle, using a 1-deep address pipeline.
  - After ptr = DEPTH-1 it moves to DRAIN.
- **DRAIN.** Performs the final compare, then returns to IDLE with Done=1. A verify takes DEPTH+1 cycles.
- **Compare rule.** On mismatch of Rd_Data against P(Cl, a):
  - Err_Cnt increments, saturating at 2**CNT_W-1.
  - On the first mismatch only, Err_Addr <= a and Fail <= 1.
  - Fail stays set until the next Start_Verify or Rst.
- **During a sweep.** Busy=1 from the cycle after the start is sampled through the cycle in which Done pulses; Busy=0 after it. While Busy, Start_*, Mem_Write and Mem_Addr are ignored.
- **LED.**
  - LED = Rd_Data[8*Byte_Sel +: 8] (combinational mux) when IDLE and Mem_Write=0.
  - A Byte_Sel beyond DATA_W/8-1 gives LED=0.
  - LED=0 when Mem_Write=1 or Busy=1.
- **Reset mid-sweep.** Aborts with no Done pulse; a partial fill remains in the RAM.

Test Plan:
- **Manual readback.** Rst; manual write C=01 at addr 5; read addr 5. Required: LED = 78, 56, 34, 12 for Byte_Sel = 0..3, each valid 1 cycle after the address.
- **Fill then verify, C=11.** Start_Fill with C=11: Busy for 64 cycles, then Done pulses. Then Start_Verify: Done after 65 cycles with Fail=0 and Err_Cnt=0.
- **Single corruption.** Fill with C=00; manually write C=10 at addr 9 and at addr 40; verify with C=00. Required: Fail=1, Err_Cnt=2, Err_Addr=9.
- **Saturation.** Set CNT_W=4; fill with C=00; verify with C=01. Required: Err_Cnt=15, Err_Addr=0.
- **Priority and ignored inputs.**
  - Assert Start_Fill and Start_Verify together: a fill runs.
  - Toggle Start_Verify and Mem_Write mid-fill: no effect, and Done arrives exactly at cycle 64.
- **Reset mid-sweep.** Assert Rst at verify cycle 20. Required: next cycle Busy=0, Fail=0, Err_Cnt=0, LED=0, and no Done pulse. A subsequent verify still passes.

Source files
------------

// File: rtl/ram_pattern_tester_if.sv
// Bus bundle for ram_pattern_tester: manual RAM access, sweep control and
// status/LED readback.
//   master : the board side (switches/buttons in, status/LED out)
//   slave  : the tester itself
// Mem_Addr/Mem_Write/C/Byte_Sel/Start_Fill/Start_Verify flow master->slave;
// Busy/Done/Fail/Err_Cnt/Err_Addr/LED flow slave->master.
interface ram_pattern_tester_if #(
  parameter int ADDR_W = 6,
  parameter int BSEL_W = 2,
  parameter int CNT_W  = 8
);
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Write;
  logic [1:0]        C;
  logic [BSEL_W-1:0] Byte_Sel;
  logic              Start_Fill;
  logic              Start_Verify;
  logic              Busy;
  logic              Done;
  logic              Fail;
  logic [CNT_W-1:0]  Err_Cnt;
  logic [ADDR_W-1:0] Err_Addr;
  logic [7:0]        LED;

  modport master (
    output Mem_Addr, Mem_Write, C, Byte_Sel, Start_Fill, Start_Verify,
    input  Busy, Done, Fail, Err_Cnt, Err_Addr, LED
  );

  modport slave (
    input  Mem_Addr, Mem_Write, C, Byte_Sel, Start_Fill, Start_Verify,
    output Busy, Done, Fail, Err_Cnt, Err_Addr, LED
  );
endinterface

// File: rtl/ram_pattern_tester.sv
// Block-RAM self-tester: a DEPTH x DATA_W synchronous single-port RAM with
// manual pattern writes / byte readback on LED, plus automatic fill and
// verify sweeps with saturating error count and first-failure capture.
// Ports:
//   Clk, Rst : clock, synchronous active-high reset
//   bus      : ram_pattern_tester_if.slave (manual access, starts, status, LED)
// Sweep timing: Busy rises the cycle after a start is sampled; Done pulses in
// the last busy cycle (fill: DEPTH busy cycles, verify: DEPTH+1). Verify
// results (Fail/Err_Cnt/Err_Addr) are final the cycle after Done.
module ram_pattern_tester #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int BSEL_W = 2,
  parameter int CNT_W  = 8
) (
  input logic             Clk,
  input logic             Rst,
  ram_pattern_tester_if.slave bus
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int NBYTES = DATA_W/8;
  localparam int REP    = (DATA_W + 31)/32;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, FILL, VERIFY, DRAIN} state_t;

  // 32-bit base repeated across the word, then cut to DATA_W.
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] c, input logic [ADDR_W-1:0] a);
    logic [31:0]       base;
    logic [32*REP-1:0] rep;
    case (c)
      2'b00:   base = 32'h0055_7523;
      2'b01:   base = 32'h1234_5678;
      2'b10:   base = 32'h8765_4321;
      default: base = 32'(a);
    endcase
    rep = {REP{base}};
    return rep[DATA_W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]          cl_q, cl_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                we, re;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [7:0]          led;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cl_d       = cl_q;
    cmp_vld_d  = 1'b0;
    cmp_addr_d = ptr_q;
    fail_d     = fail_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    we         = 1'b0;
    wr_addr    = ptr_q;
    wr_data    = pat(cl_q, ptr_q);
    re         = 1'b0;
    rd_addr    = ptr_q;

    case (state_q)
      IDLE: begin
        // A start wins over a same-cycle manual write, which is dropped.
        if (bus.Start_Fill) begin
          state_d = FILL;
          ptr_d   = '0;
          cl_d    = bus.C;
        end else if (bus.Start_Verify) begin
          state_d    = VERIFY;
          ptr_d      = '0;
          cl_d       = bus.C;
          fail_d     = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
        end else if (bus.Mem_Write) begin
          we      = 1'b1;
          wr_addr = bus.Mem_Addr;
          wr_data = pat(bus.C, bus.Mem_Addr);
        end
        if (!bus.Mem_Write) begin
          re      = 1'b1;
          rd_addr = bus.Mem_Addr;
        end
      end
      FILL: begin
        we    = 1'b1;
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST) state_d = IDLE;
      end
      VERIFY: begin
        re        = 1'b1;
        cmp_vld_d = 1'b1;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Compare stage: data for the address read last cycle is in rd_data_q.
    if (cmp_vld_q && (rd_data_q != pat(cl_q, cmp_addr_q))) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (!fail_q) begin
        fail_d     = 1'b1;
        err_addr_d = cmp_addr_q;
      end
    end

    rd_data_d = re ? mem_q[rd_addr] : rd_data_q;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DRAIN) || ((state_d == FILL) && (ptr_d == LAST));
  end

  // RAM array is never reset; a write coinciding with Rst is suppressed so a
  // reset cleanly aborts a fill.
  always_ff @(posedge Clk) begin
    if (we && !Rst) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cl_q       <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cl_q       <= cl_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Byte selects past the top byte fall through to 0.
  always_comb begin
    led = 8'h00;
    if ((state_q == IDLE) && !bus.Mem_Write) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.Byte_Sel == BSEL_W'(i)) led = rd_data_q[8*i +: 8];
      end
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Fail     = fail_q;
  assign bus.Err_Cnt  = err_cnt_q;
  assign bus.Err_Addr = err_addr_q;
  assign bus.LED      = led;
endmodule

// File: tb/tb_ram_pattern_tester.sv
// Bench for ram_pattern_tester: directed scenarios plus random manual
// writes/reads and sweeps, checked every cycle against a behavioural model
// (model RAM array + pattern function + mismatch scan), with a few literal
// expectations pinning the model.
module tb_ram_pattern_tester;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int BW = 3;
  localparam int CW = 4;
  localparam int N  = 2**AW;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  ram_pattern_tester_if #(.ADDR_W(AW), .BSEL_W(BW), .CNT_W(CW)) bus ();

  ram_pattern_tester #(.ADDR_W(AW), .DATA_W(DW), .BSEL_W(BW), .CNT_W(CW)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0]   mem_m [N];
  logic [31:0]   rd_m;
  bit            led_known, chk_en, led_chk, err_chk;
  logic          exp_busy, exp_done, exp_fail;
  logic [7:0]    exp_led;
  logic [CW-1:0] exp_cnt;
  logic [AW-1:0] exp_eaddr;
  logic          p_mw;
  logic [AW-1:0] p_addr;
  logic [1:0]    p_c;

  function automatic logic [31:0] pat(input logic [1:0] c, input int a);
    case (c)
      2'd0:    return 32'h0055_7523;
      2'd1:    return 32'h1234_5678;
      2'd2:    return 32'h8765_4321;
      default: return 32'(a);
    endcase
  endfunction

  function automatic logic [7:0] led_of(input logic [31:0] rd, input int bsel);
    if (bsel >= DW/8) return 8'h00;
    return rd[8*bsel +: 8];
  endfunction

  // Outcome of comparing the first n words of the model RAM with P(c,a).
  task automatic scan(input logic [1:0] c, input int n, output logic f,
                      output logic [CW-1:0] cnt, output logic [AW-1:0] fa);
    int e = 0;
    fa = '0;
    for (int a = 0; a < n; a++) begin
      if (mem_m[a] !== pat(c, a)) begin
        if (e == 0) fa = AW'(a);
        e++;
      end
    end
    f   = (e > 0);
    cnt = (e > 2**CW - 1) ? '1 : CW'(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.Busy), 32'(exp_busy));
      chk("done", 32'(bus.Done), 32'(exp_done));
      if (led_chk) chk("led", 32'(bus.LED), 32'(exp_led));
      if (err_chk) begin
        chk("fail", 32'(bus.Fail), 32'(exp_fail));
        chk("err_cnt", 32'(bus.Err_Cnt), 32'(exp_cnt));
        chk("err_addr", 32'(bus.Err_Addr), 32'(exp_eaddr));
      end
    end
  end

  task automatic drive_idle(input logic mw, input int addr, input int c, input int bsel);
    bus.Mem_Write    = mw;
    bus.Mem_Addr     = AW'(addr);
    bus.C            = 2'(c);
    bus.Byte_Sel     = BW'(bsel);
    bus.Start_Fill   = 1'b0;
    bus.Start_Verify = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_led  = mw ? 8'h00 : led_of(rd_m, bsel);
    led_chk  = mw || led_known;
    err_chk  = 1'b1;
    p_mw     = mw;
    p_addr   = AW'(addr);
    p_c      = 2'(c);
  endtask

  task automatic tick();
    @(posedge Clk); #1;
    if (p_mw) begin
      mem_m[p_addr] = pat(p_c, int'(p_addr));
      led_known     = 1'b0;
    end else begin
      rd_m      = mem_m[p_addr];
      led_known = 1'b1;
    end
  endtask

  // One sweep with random noise on every input while busy; rst_at>0 pulses
  // Rst during that busy cycle and abandons the sweep.
  task automatic sweep(input bit fill, input int c, input bit both, input int rst_at);
    int         len;
    int         bs;
    logic [1:0] cl;
    logic       mw;
    len = fill ? N : N + 1;
    cl  = 2'(c);
    mw  = 1'($urandom);
    bs  = $urandom_range(0, 7);
    bus.Start_Fill   = fill | both;
    bus.Start_Verify = !fill | both;
    bus.C            = cl;
    bus.Mem_Write    = mw;
    bus.Mem_Addr     = AW'($urandom);
    bus.Byte_Sel     = BW'(bs);
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_led  = mw ? 8'h00 : led_of(rd_m, bs);
    led_chk  = mw || led_known;
    err_chk  = 1'b1;
    @(posedge Clk); #1;
    for (int k = 1; k <= len; k++) begin
      bus.Start_Fill   = 1'($urandom);
      bus.Start_Verify = 1'($urandom);
      bus.Mem_Write    = 1'($urandom);
      bus.Mem_Addr     = AW'($urandom);
      bus.C            = 2'($urandom);
      bus.Byte_Sel     = BW'($urandom);
      exp_busy = 1'b1;
      exp_done = (k == len);
      exp_led  = 8'h00;
      led_chk  = 1'b1;
      // compare results for address a are visible from busy cycle a+3
      if (!fill) scan(cl, (k > 2) ? k - 2 : 0, exp_fail, exp_cnt, exp_eaddr);
      if (k == rst_at) Rst = 1'b1;
      @(posedge Clk); #1;
      if (k == rst_at) begin
        Rst       = 1'b0;
        rd_m      = '0;
        led_known = 1'b1;
        exp_fail  = 1'b0;
        exp_cnt   = '0;
        exp_eaddr = '0;
        drive_idle(1'b0, 0, 0, 0);
        return;
      end
    end
    if (fill) begin
      for (int a = 0; a < N; a++) mem_m[a] = pat(cl, a);
    end else begin
      scan(cl, N, exp_fail, exp_cnt, exp_eaddr);
    end
    led_known = 1'b0;
    drive_idle(1'b0, 0, 0, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tbl [4];
    tbl[0] = 8'h78; tbl[1] = 8'h56; tbl[2] = 8'h34; tbl[3] = 8'h12;
    for (int a = 0; a < N; a++) mem_m[a] = '0;
    rd_m      = '0;
    led_known = 1'b1;
    chk_en    = 1'b0;
    exp_fail  = 1'b0;
    exp_cnt   = '0;
    exp_eaddr = '0;
    drive_idle(1'b0, 0, 0, 0);
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst    = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_fail", 32'(bus.Fail), 0);
    chk("rst_cnt", 32'(bus.Err_Cnt), 0);
    chk("rst_eaddr", 32'(bus.Err_Addr), 0);
    chk("rst_led", 32'(bus.LED), 0);

    // manual write/readback
    drive_idle(1'b1, 5, 1, 0); tick();
    drive_idle(1'b0, 5, 1, 0); tick();
    for (int b = 0; b < 4; b++) begin
      drive_idle(1'b0, 5, 1, b); #1;
      chk("man_led", 32'(bus.LED), 32'(tbl[b]));
      tick();
    end
    drive_idle(1'b0, 5, 1, 6); #1;
    chk("led_oob", 32'(bus.LED), 0);
    tick();

    // fill/verify with address pattern
    sweep(1'b1, 3, 1'b0, 0);
    sweep(1'b0, 3, 1'b0, 0); #1;
    chk("v11_fail", 32'(bus.Fail), 0);
    chk("v11_cnt", 32'(bus.Err_Cnt), 0);

    // two corrupted words
    sweep(1'b1, 0, 1'b0, 0);
    drive_idle(1'b1, 9, 2, 0);  tick();
    drive_idle(1'b1, 40, 2, 0); tick();
    sweep(1'b0, 0, 1'b0, 0); #1;
    chk("cor_fail", 32'(bus.Fail), 1);
    chk("cor_cnt", 32'(bus.Err_Cnt), 2);
    chk("cor_eaddr", 32'(bus.Err_Addr), 9);

    // saturation
    sweep(1'b1, 0, 1'b0, 0);
    sweep(1'b0, 1, 1'b0, 0); #1;
    chk("sat_cnt", 32'(bus.Err_Cnt), 15);
    chk("sat_eaddr", 32'(bus.Err_Addr), 0);

    // both starts: fill wins
    sweep(1'b1, 2, 1'b1, 0);
    sweep(1'b0, 2, 1'b0, 0); #1;
    chk("pri_fail", 32'(bus.Fail), 0);

    // reset during a failing verify
    sweep(1'b0, 1, 1'b0, 20); #1;
    chk("rv_busy", 32'(bus.Busy), 0);
    chk("rv_fail", 32'(bus.Fail), 0);
    chk("rv_cnt", 32'(bus.Err_Cnt), 0);
    chk("rv_led", 32'(bus.LED), 0);
    tick();
    sweep(1'b0, 2, 1'b0, 0); #1;
    chk("rv_after_fail", 32'(bus.Fail), 0);

    // random mix
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        drive_idle(1'b1, $urandom_range(0, N-1), $urandom_range(0, 3), $urandom_range(0, 7));
        tick();
      end else if (op < 7) begin
        drive_idle(1'b0, $urandom_range(0, N-1), $urandom_range(0, 3), $urandom_range(0, 7));
        tick();
      end else if (op == 7) begin
        sweep(1'b1, $urandom_range(0, 3), 1'($urandom), 0);
      end else begin
        sweep(1'b0, $urandom_range(0, 3), 1'b0, 0);
      end
    end
    drive_idle(1'b0, 0, 0, 0);
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
